hilo_muldiv_unit: RTL

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers. It sits directly downstream of the ALU decoder. It consumes the decoder's `alu_control`, `HI_write_enable` and `LO_write_enable` together with the rs/rt operand values. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and raises `busy` so the core stalls issue while a 32-iteration operation is in flight.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/muldiv_iter.sv | 85 ++++++++
 rtl/hilo_muldiv_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core datapath. The ALU control encoding is
// the same one the ALU decoder drives, so every consumer of alu_control
// imports it from here and never keeps a private copy.
//
// Contents:
//   alu_control_t   5-bit decoder control code (HI/LO related subset)
//   isMulDiv()      true for codes that start a multi-cycle mul/div
//   isSignedOp()    true for codes whose operands are two's complement
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [4:0] {
        CONTROL_MULT  = 5'b10000,
        CONTROL_MULTU = 5'b10001,
        CONTROL_DIV   = 5'b10010,
        CONTROL_DIVU  = 5'b10011,
        CONTROL_MTLO  = 5'b10101,
        CONTROL_MTHI  = 5'b10110
    } alu_control_t;

    function automatic logic isMulDiv(input alu_control_t ctl);
        return (ctl == CONTROL_MULT) || (ctl == CONTROL_MULTU) ||
               (ctl == CONTROL_DIV)  || (ctl == CONTROL_DIVU);
    endfunction

    function automatic logic isSignedOp(input alu_control_t ctl);
        return (ctl == CONTROL_MULT) || (ctl == CONTROL_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// Radix-2 iteration engine shared by multiply and divide. Holds the 2*WIDTH
// shift register, the second operand and the iteration counter. It works on
// unsigned magnitudes only; signs are handled by the parent.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   i_load       load i_opA into the low half, clear the high half and counter
//   i_is_div     selects restoring divide (1) or shift-add multiply (0)
//   i_step       perform one iteration this cycle
//   i_opA        multiplier / dividend
//   i_opB        multiplicand / divisor
//   o_last       the current step is the final (WIDTH-th) one
//   o_result     multiply: {high, low} product; divide: {remainder, quotient}
// ---------------------------------------------------------------------------
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_is_div,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_opA,
    input  logic [WIDTH-1:0]   i_opB,
    output logic               o_last,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [CW-1:0]      r_count;

    logic [WIDTH:0]     w_sum;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_accNext;

    // Divide treats the top WIDTH+1 bits of the shifted register as the trial
    // remainder. When it is at least the divisor the true difference is below
    // the divisor, so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_operand};
        w_fits    = r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_operand};
        w_diff    = r_acc[2*WIDTH-2:WIDTH-1] - r_operand;
        w_accNext = r_acc;
        if (i_is_div) begin
            if (w_fits) begin
                w_accNext = {w_diff, r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_accNext = {r_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                w_accNext = {w_sum, r_acc[WIDTH-1:1]};
            end else begin
                w_accNext = {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end
    end

    // Load primes the register with the first operand in the low half; each
    // step then advances the shift register and the iteration count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_operand <= '0;
            r_count   <= '0;
        end else if (i_load) begin
            r_acc     <= {{WIDTH{1'b0}}, i_opA};
            r_operand <= i_opB;
            r_count   <= '0;
        end else if (i_step) begin
            r_acc     <= w_accNext;
            r_count   <= r_count + CW'(1);
        end
    end

    assign o_last   = (r_count == CW'(WIDTH - 1));
    assign o_result = r_acc;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
// Multi-cycle multiply/divide unit that owns the architectural HI and LO
// registers. MTHI/MTLO write in one cycle; MULT/MULTU/DIV/DIVU run through
// IDLE -> CALC (WIDTH iterations) -> FIX and then pulse done.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             instruction valid in this stage
//   alu_control       decoder control code
//   HI_write_enable   decoder HI write enable
//   LO_write_enable   decoder LO write enable
//   op_a, op_b        rs and rt operand values
//   busy              unit occupied, issue must stall
//   done              one-cycle pulse after a mul/div result is committed
//   hi, lo            architectural HI and LO registers
// ---------------------------------------------------------------------------
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  alu_control_t     alu_control,
    input  logic             HI_write_enable,
    input  logic             LO_write_enable,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t IDLE = 2'd0;
    localparam muldiv_state_t CALC = 2'd1;
    localparam muldiv_state_t FIX  = 2'd2;

    muldiv_state_t r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_isDiv;
    logic             r_negLo;
    logic             r_negHi;
    logic             r_divZero;
    logic [WIDTH-1:0] r_opA;

    logic               w_accept;
    logic               w_signedOp;
    logic               w_load;
    logic               w_last;
    logic [WIDTH-1:0]   w_iterA;
    logic [WIDTH-1:0]   w_iterB;
    logic [2*WIDTH-1:0] w_result;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    // Starts while busy are dropped rather than queued; the core stalls issue.
    assign w_accept   = start & ~r_busy & (HI_write_enable | LO_write_enable);
    assign w_signedOp = isSignedOp(alu_control);
    assign w_load     = (r_state == IDLE) & w_accept & isMulDiv(alu_control);

    // Signed ops iterate on magnitudes. The most negative value negates to
    // itself, which read as unsigned is exactly its magnitude.
    assign w_iterA = (w_signedOp && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_iterB = (w_signedOp && op_b[WIDTH-1]) ? -op_b : op_b;

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_is_div(r_isDiv),
        .i_step  (r_state == CALC),
        .i_opA   (w_iterA),
        .i_opB   (w_iterB),
        .o_last  (w_last),
        .o_result(w_result)
    );

    // Sign fixup of the finished magnitude result. A zero divisor bypasses
    // the fixup entirely: all-ones quotient and the original dividend in HI.
    always_comb begin
        w_product = r_negLo ? -w_result : w_result;
        w_fixHi   = w_product[2*WIDTH-1:WIDTH];
        w_fixLo   = w_product[WIDTH-1:0];
        if (r_isDiv) begin
            if (r_divZero) begin
                w_fixHi = r_opA;
                w_fixLo = '1;
            end else begin
                w_fixHi = r_negHi ? -w_result[2*WIDTH-1:WIDTH] : w_result[2*WIDTH-1:WIDTH];
                w_fixLo = r_negLo ? -w_result[WIDTH-1:0] : w_result[WIDTH-1:0];
            end
        end
    end

    // Control FSM and HI/LO ownership. HI/LO only change on an MTHI/MTLO
    // accept or at the FIX edge, so partial results are never visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_isDiv   <= 1'b0;
            r_negLo   <= 1'b0;
            r_negHi   <= 1'b0;
            r_divZero <= 1'b0;
            r_opA     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (alu_control == CONTROL_MTHI && HI_write_enable) begin
                            r_hi <= op_a;
                        end else if (alu_control == CONTROL_MTLO && LO_write_enable) begin
                            r_lo <= op_a;
                        end else if (isMulDiv(alu_control)) begin
                            r_isDiv   <= (alu_control == CONTROL_DIV) ||
                                         (alu_control == CONTROL_DIVU);
                            r_negLo   <= w_signedOp & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            r_negHi   <= w_signedOp & op_a[WIDTH-1];
                            r_divZero <= (op_b == '0);
                            r_opA     <= op_a;
                            r_busy    <= 1'b1;
                            r_state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (w_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_hi    <= w_fixHi;
                    r_lo    <= w_fixLo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
